// File: rtl/switch_pkg.sv
// Shared definitions for the 4x4 switch arbiter.
//   NUM_PORTS      : number of inputs and outputs
//   PORT_IDX_W     : width of a port index
//   TIMEOUT_CYCLES : busy cycles before the optional watchdog forces a release
//   arb_state_t    : per-output arbitration state
//   is_onehot()    : true when exactly one bit of a destination vector is set
package switch_pkg;

   localparam int NUM_PORTS      = 4;
   localparam int PORT_IDX_W     = 2;
   localparam int TIMEOUT_CYCLES = 255;
   localparam int WD_W           = 8;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
      return (v != '0) && ((v & (v - NUM_PORTS'(1))) == '0);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among up to four requesters.
//   req : request bits, one per input
//   ptr : index where the search starts; the search moves upward modulo 4
//   gnt : one-hot winner (all zero when nothing requests)
//   idx : index of the winner (equals ptr when nothing requests)
import switch_pkg::*;

module rr_arbiter (
   input  logic [NUM_PORTS-1:0]  req,
   input  logic [PORT_IDX_W-1:0] ptr,
   output logic [NUM_PORTS-1:0]  gnt,
   output logic [PORT_IDX_W-1:0] idx
);

   logic [PORT_IDX_W-1:0] probe;
   logic                  found;

   always_comb begin
      gnt   = '0;
      idx   = ptr;
      found = 1'b0;
      probe = ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         // 2-bit index addition wraps modulo 4 on its own
         probe = ptr + PORT_IDX_W'(k);
         if (!found && req[probe]) begin
            found      = 1'b1;
            gnt[probe] = 1'b1;
            idx        = probe;
         end
      end
   end

endmodule

// File: rtl/switch_arbiter.sv
// Output-port arbiter for a 4x4 switch. Each output runs its own IDLE/BUSY
// FSM and picks among competing inputs round-robin.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous, active-low reset
//   req      : req[i] = input i holds a packet
//   req_tgt  : bits [4i+3:4i] = one-hot destination of input i
//   done     : done[i] = one-cycle end-of-packet pulse from input i
//   gnt      : gnt[i] = input i owns its destination output
//   out_busy : out_busy[o] = output o is owned
//   out_sel  : bits [2o+1:2o] = owning input of output o, 0 when idle
//   tgt_err  : tgt_err[i] = input i requested with a zero/multi-hot target
//   timeout  : timeout[o] = output o was forcibly released by its watchdog
// Optional feature: define ARB_TIMEOUT_EN to add an 8-bit watchdog per
// output; without it timeout is tied low.
import switch_pkg::*;

module switch_arbiter (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS*NUM_PORTS-1:0]  req_tgt,
   input  logic [NUM_PORTS-1:0]            done,
   output logic [NUM_PORTS-1:0]            gnt,
   output logic [NUM_PORTS-1:0]            out_busy,
   output logic [NUM_PORTS*PORT_IDX_W-1:0] out_sel,
   output logic [NUM_PORTS-1:0]            tgt_err,
   output logic [NUM_PORTS-1:0]            timeout
);

   logic [NUM_PORTS-1:0]                tgt_ok;
   logic [NUM_PORTS-1:0]                tgt_err_reg;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] own_mat;   // [output][input]

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
      assign tgt_ok[gi] = is_onehot(req_tgt[NUM_PORTS*gi +: NUM_PORTS]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tgt_err_reg <= '0;
      end else begin
         tgt_err_reg <= req & ~tgt_ok;
      end
   end

   assign tgt_err = tgt_err_reg;

   // Each input targets exactly one output, so at most one row of own_mat
   // can hold a given input; the OR is the input's grant.
   always_comb begin
      gnt = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         gnt = gnt | own_mat[o];
      end
   end

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      arb_state_t            state_reg, state_next;
      logic [PORT_IDX_W-1:0] owner_reg, owner_next;
      logic [PORT_IDX_W-1:0] ptr_reg, ptr_next;
      logic [PORT_IDX_W-1:0] win_idx;
      logic [NUM_PORTS-1:0]  cand, win_oh;
      logic                  owner_leaves;
`ifdef ARB_TIMEOUT_EN
      logic [WD_W-1:0]       wd_reg, wd_next;
      logic                  timeout_reg, timeout_next;
`endif

      // Already-granted inputs are excluded so a target change while
      // granted cannot produce a second grant.
      always_comb begin
         cand = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = req[i] & tgt_ok[i] & req_tgt[NUM_PORTS*i + gi] & ~gnt[i];
         end
      end

      rr_arbiter u_rr (
         .req (cand),
         .ptr (ptr_reg),
         .gnt (win_oh),
         .idx (win_idx)
      );

      assign owner_leaves = done[owner_reg] | ~req[owner_reg];

      always_comb begin
         state_next   = state_reg;
         owner_next   = owner_reg;
         ptr_next     = ptr_reg;
`ifdef ARB_TIMEOUT_EN
         wd_next      = '0;
         timeout_next = 1'b0;
`endif
         case (state_reg)
            ARB_IDLE: begin
               if (|win_oh) begin
                  state_next = ARB_BUSY;
                  owner_next = win_idx;
                  ptr_next   = win_idx + PORT_IDX_W'(1);
               end
            end
            ARB_BUSY: begin
               // Busy never grants, which guarantees an idle cycle
               // between consecutive owners.
               if (owner_leaves) begin
                  state_next = ARB_IDLE;
                  owner_next = '0;
               end
`ifdef ARB_TIMEOUT_EN
               else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  state_next   = ARB_IDLE;
                  owner_next   = '0;
                  timeout_next = 1'b1;
               end else begin
                  wd_next = wd_reg + WD_W'(1);
               end
`endif
            end
            default: begin
               state_next = ARB_IDLE;
               owner_next = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_reg   <= ARB_IDLE;
            owner_reg   <= '0;
            ptr_reg     <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
`endif
         end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
`ifdef ARB_TIMEOUT_EN
            wd_reg      <= wd_next;
            timeout_reg <= timeout_next;
`endif
         end
      end

      assign out_busy[gi]                       = (state_reg == ARB_BUSY);
      assign out_sel[PORT_IDX_W*gi +: PORT_IDX_W] = owner_reg;
      assign own_mat[gi] = (state_reg == ARB_BUSY) ?
                           (NUM_PORTS'(1) << owner_reg) : '0;
`ifdef ARB_TIMEOUT_EN
      assign timeout[gi] = timeout_reg;
`endif
   end

`ifndef ARB_TIMEOUT_EN
   assign timeout = '0;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Testbench for switch_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level model of the
// arbitration rules.
module tb_switch_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO_LIMIT = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_tgt;
   logic [3:0]  done;
   logic [3:0]  gnt;
   logic [3:0]  out_busy;
   logic [7:0]  out_sel;
   logic [3:0]  tgt_err;
   logic [3:0]  timeout;

   always #5 clk = ~clk;

   switch_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_tgt  (req_tgt),
      .done     (done),
      .gnt      (gnt),
      .out_busy (out_busy),
      .out_sel  (out_sel),
      .tgt_err  (tgt_err),
      .timeout  (timeout)
   );

   int checks   = 0;
   int failures = 0;

   // model: owner of each output (-1 = free), search start, cycles owned
   int m_owner [4];
   int m_ptr   [4];
   int m_held  [4];
   bit m_terr  [4];
   bit m_to    [4];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_gnt();
      logic [3:0] g = '0;
      for (int o = 0; o < 4; o++) if (m_owner[o] >= 0) g[m_owner[o]] = 1'b1;
      return g;
   endfunction

   // Apply the arbitration rules for one clock edge using current inputs.
   task automatic model_edge();
      logic [3:0] pg;
      logic [3:0] tgt;
      int i;
      int own;
      pg = model_gnt();
      for (int o = 0; o < 4; o++) begin
         m_to[o] = 1'b0;
         if (!rst_n) begin
            m_owner[o] = -1;
            m_ptr[o]   = 0;
            m_held[o]  = 0;
         end else if (m_owner[o] < 0) begin
            for (int k = 0; k < 4; k++) begin
               i   = (m_ptr[o] + k) % 4;
               tgt = req_tgt[4*i +: 4];
               if (m_owner[o] < 0 && req[i] && tgt == 4'(1 << o) && !pg[i]) begin
                  m_owner[o] = i;
                  m_ptr[o]   = (i + 1) % 4;
                  m_held[o]  = 0;
               end
            end
         end else begin
            own = m_owner[o];
            if (done[own] || !req[own]) begin
               m_owner[o] = -1;
            end else begin
               m_held[o]++;
               if (TO_EN && m_held[o] >= TO_LIMIT) begin
                  m_owner[o] = -1;
                  m_to[o]    = 1'b1;
               end
            end
         end
      end
      for (int n = 0; n < 4; n++) begin
         tgt       = req_tgt[4*n +: 4];
         m_terr[n] = rst_n && req[n] && ($countones(tgt) != 1);
      end
   endtask

   task automatic compare_all();
      logic [3:0] e_busy, e_terr, e_to;
      logic [7:0] e_sel;
      e_busy = '0; e_terr = '0; e_to = '0; e_sel = '0;
      for (int o = 0; o < 4; o++) begin
         e_busy[o] = (m_owner[o] >= 0);
         e_to[o]   = m_to[o];
         e_terr[o] = m_terr[o];
         if (m_owner[o] >= 0) e_sel[2*o +: 2] = 2'(m_owner[o]);
      end
      chk("gnt", 16'(gnt), 16'(model_gnt()));
      chk("out_busy", 16'(out_busy), 16'(e_busy));
      chk("out_sel", 16'(out_sel), 16'(e_sel));
      chk("tgt_err", 16'(tgt_err), 16'(e_terr));
      chk("timeout", 16'(timeout), 16'(e_to));
   endtask

   // One clock: model the edge, sample #1 after it, return at the negedge.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   initial begin
      int held;
      int to_seen;
      logic [3:0] t;

      for (int o = 0; o < 4; o++) begin
         m_owner[o] = -1; m_ptr[o] = 0; m_held[o] = 0; m_terr[o] = 0; m_to[o] = 0;
      end
      rst_n = 1'b0; req = '0; req_tgt = '0; done = '0;
      @(negedge clk);

      // reset
      cycle(); cycle();
      chk("rst_gnt", 16'(gnt), 16'h0);
      chk("rst_busy", 16'(out_busy), 16'h0);
      rst_n = 1'b1;
      cycle();

      // single request: input 0 -> output 2
      req = 4'b0001; req_tgt = 16'h0004;
      cycle();
      chk("single_gnt", 16'(gnt), 16'h1);
      chk("single_busy", 16'(out_busy), 16'h4);
      chk("single_sel", 16'(out_sel[5:4]), 16'h0);
      done = 4'b0001;
      cycle();
      chk("single_clr_gnt", 16'(gnt), 16'h0);
      chk("single_clr_busy", 16'(out_busy), 16'h0);
      done = '0; req = '0;
      cycle();

      // contention: inputs 0,1,2 -> output 3, each holds 3 cycles
      req = 4'b0111; req_tgt = 16'h0888;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk($sformatf("rr_order%0d", k), 16'(gnt), 16'(1 << k));
         cycle(); cycle();
         done[k] = 1'b1;
         cycle();
         chk($sformatf("rr_idle%0d", k), 16'(out_busy), 16'h0);
         done[k] = 1'b0; req[k] = 1'b0;
      end
      cycle();
      // pointer now 3: input 3 beats input 0
      req = 4'b1001; req_tgt = 16'h8008;
      cycle();
      chk("rr_ptr3", 16'(gnt), 16'h8);
      done = 4'b1000;
      cycle();
      done = '0; req = '0;
      cycle();

      // parallel: input 0 -> output 1, input 2 -> output 3
      req = 4'b0101; req_tgt = 16'h0802;
      cycle();
      chk("par_gnt", 16'(gnt), 16'h5);
      chk("par_sel1", 16'(out_sel[3:2]), 16'h0);
      chk("par_sel3", 16'(out_sel[7:6]), 16'h2);
      req = '0;
      cycle();

      // bad target on input 1 for 2 cycles
      req = 4'b0010; req_tgt = 16'h0060;
      cycle();
      chk("bad_err0", 16'(tgt_err), 16'h2);
      chk("bad_gnt0", 16'(gnt), 16'h0);
      cycle();
      chk("bad_err1", 16'(tgt_err), 16'h2);
      req = '0;
      cycle();
      chk("bad_err_off", 16'(tgt_err), 16'h0);

      // reset mid-ownership: input 3 owns output 0, input 1 owns output 2
      req = 4'b1010; req_tgt = 16'h1040;
      cycle();
      chk("pre_rst_gnt", 16'(gnt), 16'hA);
      rst_n = 1'b0; req = '0;
      cycle();
      chk("mid_rst_gnt", 16'(gnt), 16'h0);
      chk("mid_rst_busy", 16'(out_busy), 16'h0);
      chk("mid_rst_to", 16'(timeout), 16'h0);
      rst_n = 1'b1;
      // output 2 pointer back at 0: input 1 wins over input 3
      req = 4'b1010; req_tgt = 16'h4040;
      cycle();
      chk("rst_ptr0", 16'(gnt), 16'h2);
      req = '0;
      cycle();

      // owner never finishes
      held = 0; to_seen = 0;
      req = 4'b0001; req_tgt = 16'h0001;
      for (int c = 0; c < 300; c++) begin
         cycle();
         if (gnt[0]) held++;
         if (timeout[0]) begin
            to_seen++;
            break;
         end
      end
`ifdef ARB_TIMEOUT_EN
      chk("wd_held", 16'(held), 16'd255);
      chk("wd_pulse", 16'(to_seen), 16'd1);
`else
      chk("nowd_held", 16'(held), 16'd300);
      chk("nowd_pulse", 16'(to_seen), 16'd0);
`endif
      req = '0;
      cycle();
      chk("wd_pulse_end", 16'(timeout), 16'h0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(99) != 0);
         req   = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(99) < 85) t = 4'(1 << $urandom_range(3));
            else                        t = 4'($urandom);
            req_tgt[4*i +: 4] = t;
         end
         for (int i = 0; i < 4; i++) done[i] = ($urandom_range(99) < 15);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
